bus_src_sel_reg: RTL and testbench

Parametrised, registered source-select stage for the datapath B bus. It captures one of NUM_SRC source words (PC, IR, MDR, register file, and later sources) into an output register and presents it with a valid/ready handshake to the ALU B input. It replaces the purely combinational 4:1 B-bus select for multi-cycle and stall-capable datapaths. It adds illegal-select detection and a transfer counter for debug.

---
 rtl/bus_src_sel_reg_pkg.sv | 19 +
 rtl/bus_src_sel_reg_sat_counter.sv | 25 ++
 rtl/bus_src_sel_reg.sv | 109 ++++++++++
 tb/tb_bus_src_sel_reg.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_src_sel_reg_pkg.sv
// Shared CPU datapath package: B-bus source indices, default width and
// the two-state occupancy enum of the B-bus register.
package bus_src_sel_reg_pkg;

  // Source indices on the B bus. Sources beyond SRC_R are added later.
  localparam int SRC_PC  = 0;
  localparam int SRC_IR  = 1;
  localparam int SRC_MDR = 2;
  localparam int SRC_R   = 3;

  localparam int DEFAULT_DATA_W = 8;

  // IDLE: register empty, FULL: register holds an unconsumed word.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } bus_state_e;

endpackage

// File: rtl/bus_src_sel_reg_sat_counter.sv
// Saturating up-counter. It sticks at all-ones rather than wrapping, which
// keeps it usable for debug event counts that may run for a long time.
module bus_src_sel_reg_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  // Count one per inc pulse and hold once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/bus_src_sel_reg.sv
// Registered B-bus source select. It captures one of NUM_SRC source words
// into a single-entry output register with a valid/ready handshake toward the
// ALU B input. It also flags out-of-range selects and counts completed
// transfers for debug.
module bus_src_sel_reg
  import bus_src_sel_reg_pkg::*;
#(
  parameter int                 DATA_W    = DEFAULT_DATA_W,
  parameter int                 NUM_SRC   = 4,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  localparam int                SEL_W     = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      req,
  output logic                      req_ready,
  output logic [DATA_W-1:0]         bus,
  output logic                      bus_valid,
  input  logic                      bus_ready,
  output logic [SEL_W-1:0]          bus_src,
  output logic                      sel_err,
  input  logic                      err_clr,
  output logic [15:0]               xfer_cnt
);

  // One extra bit so NUM_SRC itself is representable when it is a power of
  // two. In that case every select is legal.
  localparam logic [SEL_W:0] NUM_SRC_L = (SEL_W+1)'(NUM_SRC);

  bus_state_e        state_reg, state_next;
  logic [DATA_W-1:0] bus_reg;
  logic [SEL_W-1:0]  bus_src_reg;
  logic              sel_err_reg;

  logic sel_ok;
  logic accept;
  logic illegal;
  logic consume;

  assign bus_valid = (state_reg == ST_FULL);

  // The ready signal passes through. A full register can take a new word in
  // the same cycle its current word is consumed, so the stream has no bubble.
  assign req_ready = !bus_valid || bus_ready;

  assign sel_ok  = ({1'b0, sel} < NUM_SRC_L);
  assign accept  = req && req_ready && sel_ok;
  assign illegal = req && req_ready && !sel_ok;
  assign consume = bus_valid && bus_ready;

  // Occupancy next-state logic: a load always wins over a drain.
  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = ST_FULL;
    end else if (consume) begin
      state_next = ST_IDLE;
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Capture the selected source word only on accept. A drained or stalled
  // register keeps its last word and index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_reg     <= RESET_VAL;
      bus_src_reg <= '0;
    end else if (accept) begin
      bus_reg     <= src_data[sel*DATA_W +: DATA_W];
      bus_src_reg <= sel;
    end
  end

  // Sticky illegal-select flag. A new illegal request wins over a clear
  // arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_reg <= 1'b0;
    end else if (illegal) begin
      sel_err_reg <= 1'b1;
    end else if (err_clr) begin
      sel_err_reg <= 1'b0;
    end
  end

  assign bus     = bus_reg;
  assign bus_src = bus_src_reg;
  assign sel_err = sel_err_reg;

  bus_src_sel_reg_sat_counter #(
    .W (16)
  ) u_xfer_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (consume),
    .cnt   (xfer_cnt)
  );

endmodule

// File: tb/tb_bus_src_sel_reg.sv
// Bench for bus_src_sel_reg with five sources, so illegal selects 5..7 can
// occur. A transaction-level model tracks what the B-bus register must hold.
// One negedge process compares the DUT against the model every cycle, and
// literal checks pin the directed scenarios.
module tb_bus_src_sel_reg;

  localparam int DW = 8;
  localparam int NS = 5;
  localparam int SW = 3;
  localparam logic [DW-1:0] RV = 8'hC3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NS*DW-1:0] src_data;
  logic [DW-1:0]  src_w [NS];
  logic [SW-1:0]  sel;
  logic           req;
  logic           req_ready;
  logic [DW-1:0]  bus;
  logic           bus_valid;
  logic           bus_ready;
  logic [SW-1:0]  bus_src;
  logic           sel_err;
  logic           err_clr;
  logic [15:0]    xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  assign src_data = {src_w[4], src_w[3], src_w[2], src_w[1], src_w[0]};

  bus_src_sel_reg #(
    .DATA_W    (DW),
    .NUM_SRC   (NS),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_data  (src_data),
    .sel       (sel),
    .req       (req),
    .req_ready (req_ready),
    .bus       (bus),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_src   (bus_src),
    .sel_err   (sel_err),
    .err_clr   (err_clr),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: contents of the one-word B-bus register and the debug state.
  logic          m_valid;
  logic [DW-1:0] m_bus;
  logic [SW-1:0] m_src;
  logic          m_err;
  logic [15:0]   m_cnt;

  wire m_rr    = !m_valid || bus_ready;
  wire m_legal = (int'(sel) < NS);
  wire m_take  = req && m_rr && m_legal;
  wire m_bad   = req && m_rr && !m_legal;
  wire m_cons  = m_valid && bus_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_bus   <= RV;
      m_src   <= '0;
      m_err   <= 1'b0;
      m_cnt   <= 16'd0;
    end else begin
      if (m_take) begin
        m_valid <= 1'b1;
        m_bus   <= src_w[sel];
        m_src   <= sel;
      end else if (m_cons) begin
        m_valid <= 1'b0;
      end
      if (m_cons && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      if (m_bad) m_err <= 1'b1;
      else if (err_clr) m_err <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_valid", 32'(bus_valid), 32'(m_valid));
      chk("bus", 32'(bus), 32'(m_bus));
      chk("bus_src", 32'(bus_src), 32'(m_src));
      chk("sel_err", 32'(sel_err), 32'(m_err));
      chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
      chk("req_ready", 32'(req_ready), 32'(m_rr));
    end
  end

  // Advance to just after the next rising edge, which is where inputs are driven.
  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic [SW-1:0] s, input logic br, input logic ec);
    req = r; sel = s; bus_ready = br; err_clr = ec;
  endtask

  logic [DW-1:0] b2b_exp [4];
  int guard;

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < NS; i++) src_w[i] = 8'h00;
    b2b_exp[0] = 8'h10; b2b_exp[1] = 8'h20; b2b_exp[2] = 8'h30; b2b_exp[3] = 8'h40;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_bus", 32'(bus), 32'(RV));
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_err", 32'(sel_err), 32'd0);
    $display("txn reset: bus=%0h valid=%0d cnt=%0d", bus, bus_valid, xfer_cnt);

    // Basic transfer from MDR
    drv_edge();
    src_w[2] = 8'hA5;
    set_in(1'b1, 3'd2, 1'b1, 1'b0);
    drv_edge();
    req = 1'b0;
    @(negedge clk);
    chk("basic_bus", 32'(bus), 32'hA5);
    chk("basic_src", 32'(bus_src), 32'd2);
    chk("basic_valid", 32'(bus_valid), 32'd1);
    drv_edge();
    @(negedge clk);
    chk("basic_cnt", 32'(xfer_cnt), 32'd1);
    $display("txn basic: bus=%0h src=%0d cnt=%0d", bus, bus_src, xfer_cnt);

    // Back-to-back with bus_ready held high
    drv_edge();
    for (int i = 0; i < 4; i++) src_w[i] = b2b_exp[i];
    set_in(1'b1, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drv_edge();
      if (i < 3) sel = SW'(i + 1);
      else req = 1'b0;
      @(negedge clk);
      chk("b2b_bus", 32'(bus), 32'(b2b_exp[i]));
      chk("b2b_valid", 32'(bus_valid), 32'd1);
      $display("txn b2b %0d: bus=%0h src=%0d", i, bus, bus_src);
    end
    drv_edge();
    @(negedge clk);
    // One transfer from the basic test plus four here.
    chk("b2b_cnt", 32'(xfer_cnt), 32'd5);

    // Stall: hold the R word while the source changes and a request waits.
    drv_edge();
    src_w[3] = 8'h7E;
    set_in(1'b1, 3'd3, 1'b0, 1'b0);
    drv_edge();
    req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_bus", 32'(bus), 32'h7E);
      chk("stall_rdy", 32'(req_ready), 32'd0);
      drv_edge();
      if (k == 0) begin
        src_w[3] = 8'h00;
        req = 1'b1;
      end
    end
    bus_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_rdy", 32'(req_ready), 32'd1);
    drv_edge();
    req = 1'b0;
    @(negedge clk);
    chk("stall_new_bus", 32'(bus), 32'h00);
    chk("stall_new_valid", 32'(bus_valid), 32'd1);
    chk("stall_cnt", 32'(xfer_cnt), 32'd6);
    $display("txn stall: bus=%0h cnt=%0d", bus, xfer_cnt);
    drv_edge();

    // Illegal selects
    set_in(1'b1, 3'd6, 1'b1, 1'b0);
    drv_edge();
    req = 1'b0;
    @(negedge clk);
    chk("ill_valid", 32'(bus_valid), 32'd0);
    chk("ill_err", 32'(sel_err), 32'd1);
    drv_edge();
    set_in(1'b1, 3'd7, 1'b1, 1'b1);
    drv_edge();
    set_in(1'b0, 3'd0, 1'b1, 1'b1);
    @(negedge clk);
    chk("ill_set_wins", 32'(sel_err), 32'd1);
    drv_edge();
    err_clr = 1'b0;
    @(negedge clk);
    chk("ill_clr", 32'(sel_err), 32'd0);
    $display("txn illegal: err=%0d valid=%0d", sel_err, bus_valid);

    // Asynchronous reset while full and stalled
    drv_edge();
    src_w[1] = 8'h5A;
    set_in(1'b1, 3'd1, 1'b0, 1'b0);
    drv_edge();
    req = 1'b0;
    @(negedge clk);
    chk("pre_rst_bus", 32'(bus), 32'h5A);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus_valid), 32'd0);
    chk("arst_bus", 32'(bus), 32'(RV));
    chk("arst_cnt", 32'(xfer_cnt), 32'd0);
    $display("txn async reset: bus=%0h valid=%0d cnt=%0d", bus, bus_valid, xfer_cnt);
    drv_edge();
    drv_edge();
    rst_n = 1'b1;

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      req       = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, 7));
      bus_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NS; i++) src_w[i] = 8'($urandom);
      drv_edge();
      if (n % 200 == 0) $display("txn random %0d: bus=%0h valid=%0d cnt=%0d", n, bus, bus_valid, xfer_cnt);
    end

    // Saturation: stream until the count reaches FFFE, then consume three more.
    set_in(1'b1, 3'd0, 1'b1, 1'b0);
    guard = 0;
    while (m_cnt != 16'hFFFE && guard < 70000) begin
      drv_edge();
      guard++;
    end
    if (guard >= 70000) begin
      n_checks++;
      n_fail++;
      $display("FAIL sat_reach: count stuck at %0h, wanted fffe", m_cnt);
    end
    @(negedge clk);
    chk("sat_fffe", 32'(xfer_cnt), 32'hFFFE);
    repeat (3) drv_edge();
    req = 1'b0;
    @(negedge clk);
    chk("sat_ffff", 32'(xfer_cnt), 32'hFFFF);
    repeat (3) drv_edge();
    @(negedge clk);
    chk("sat_hold", 32'(xfer_cnt), 32'hFFFF);
    $display("txn saturation: cnt=%0h", xfer_cnt);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
